// File: rtl/gate_share_arbiter_if.sv
// Bus bundle between the requesters/shared gate unit (master) and gate_share_arbiter (slave).
interface gate_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]       gnt;
    logic [1:0]               gate_op;
    logic [WIDTH-1:0]         gate_a;
    logic [WIDTH-1:0]         gate_b;
    logic [WIDTH-1:0]         gate_y;
    logic                     busy;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_data;

    modport master (
        output req, req_op, req_a, req_b, gate_y, rsp_ready,
        input  gnt, gate_op, gate_a, gate_b, busy, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req, req_op, req_a, req_b, gate_y, rsp_ready,
        output gnt, gate_op, gate_a, gate_b, busy, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/gate_share_arbiter.sv
// Round-robin sharing of one combinational gate unit (NOT/AND/OR/XOR) among NUM_REQ requesters.
// Define GATE_ARB_STATS_EN to add the grant_count / last_wait statistics outputs.
module gate_share_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 8,
    parameter int GATE_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    gate_share_arbiter_if.slave bus
`ifdef GATE_ARB_STATS_EN
    ,
    output logic [15:0] grant_count,
    output logic [7:0]  last_wait
`endif
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (GATE_LAT > 1) ? $clog2(GATE_LAT) : 1;

    typedef logic [ID_W-1:0]    id_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_r;
    id_t              rr_ptr_r;
    id_t              rsp_id_r;
    logic [CNT_W-1:0] cnt_r;
    req_vec_t         gnt_r;
    logic [1:0]       gate_op_r;
    logic [WIDTH-1:0] gate_a_r;
    logic [WIDTH-1:0] gate_b_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             busy_r;
    logic             rsp_valid_r;

    logic             sel_found_s;
    id_t              sel_idx_s;
    id_t              cand_s;
    logic [1:0]       sel_op_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic             accept_s;

    // Round-robin pick: first active request starting just above the last winner.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = {ID_W{1'b0}};
        cand_s      = {ID_W{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = id_t'((int'(rr_ptr_r) + k) % NUM_REQ);
            if (!sel_found_s && bus.req[cand_s]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Field mux for the selected requester.
    always_comb begin
        sel_op_s = 2'b00;
        sel_a_s  = {WIDTH{1'b0}};
        sel_b_s  = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (id_t'(i) == sel_idx_s) begin
                sel_op_s = bus.req_op[2*i +: 2];
                sel_a_s  = bus.req_a[WIDTH*i +: WIDTH];
                sel_b_s  = bus.req_b[WIDTH*i +: WIDTH];
            end else begin
                sel_op_s = sel_op_s;
            end
        end
    end

    assign accept_s = (state_r == ST_IDLE) && sel_found_s;

    // Control FSM with all bus outputs held in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= id_t'(NUM_REQ - 1);
            rsp_id_r    <= {ID_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            gnt_r       <= {NUM_REQ{1'b0}};
            gate_op_r   <= 2'b00;
            gate_a_r    <= {WIDTH{1'b0}};
            gate_b_r    <= {WIDTH{1'b0}};
            rsp_data_r  <= {WIDTH{1'b0}};
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            gnt_r <= {NUM_REQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        gnt_r     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx_s;
                        gate_op_r <= sel_op_s;
                        gate_a_r  <= sel_a_s;
                        gate_b_r  <= sel_b_s;
                        rsp_id_r  <= sel_idx_s;
                        rr_ptr_r  <= sel_idx_s;
                        cnt_r     <= CNT_W'(GATE_LAT - 1);
                        busy_r    <= 1'b1;
                        state_r   <= ST_EXEC;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    // gate_* stay frozen while the external unit settles.
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        rsp_data_r  <= bus.gate_y;
                        rsp_valid_r <= 1'b1;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_valid_r && bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gate_op   = gate_op_r;
    assign bus.gate_a    = gate_a_r;
    assign bus.gate_b    = gate_b_r;
    assign bus.busy      = busy_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_data  = rsp_data_r;

`ifdef GATE_ARB_STATS_EN
    logic [7:0]  wait_cnt_r [NUM_REQ];
    logic [15:0] grant_count_r;
    logic [7:0]  last_wait_r;

    // Per-requester wait tracking plus saturating grant statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count_r <= 16'h0000;
            last_wait_r   <= 8'h00;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept_s && (sel_idx_s == id_t'(i))) begin
                    wait_cnt_r[i] <= 8'h00;
                end else if (!bus.req[i]) begin
                    wait_cnt_r[i] <= 8'h00;
                end else if (wait_cnt_r[i] != 8'hFF) begin
                    wait_cnt_r[i] <= wait_cnt_r[i] + 8'h01;
                end else begin
                    wait_cnt_r[i] <= wait_cnt_r[i];
                end
            end
            if (accept_s) begin
                grant_count_r <= (grant_count_r == 16'hFFFF) ? grant_count_r : grant_count_r + 16'h0001;
                // The accept edge itself counts as one waiting cycle.
                last_wait_r   <= (wait_cnt_r[sel_idx_s] == 8'hFF) ? 8'hFF : wait_cnt_r[sel_idx_s] + 8'h01;
            end else begin
                grant_count_r <= grant_count_r;
            end
        end
    end

    assign grant_count = grant_count_r;
    assign last_wait   = last_wait_r;
`endif

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Directed, table-driven bench for gate_share_arbiter (GATE_LAT=1 and GATE_LAT=4 instances).
module tb_gate_share_arbiter;
    localparam int NR = 4;
    localparam int W  = 8;

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
    } vec_t;

    logic clk = 1'b0;
    logic rst1_n;
    logic rst4_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gate_share_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) if1 ();
    gate_share_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) if4 ();

`ifdef GATE_ARB_STATS_EN
    logic [15:0] gc1, gc4;
    logic [7:0]  lw1, lw4;
`endif

    gate_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .GATE_LAT(1)) u1 (
        .clk(clk), .rst_n(rst1_n), .bus(if1.slave)
`ifdef GATE_ARB_STATS_EN
        , .grant_count(gc1), .last_wait(lw1)
`endif
    );

    gate_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .GATE_LAT(4)) u4 (
        .clk(clk), .rst_n(rst4_n), .bus(if4.slave)
`ifdef GATE_ARB_STATS_EN
        , .grant_count(gc4), .last_wait(lw4)
`endif
    );

    // External shared gate unit.
    function automatic logic [7:0] gate_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return ~a;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb if1.gate_y = gate_fn(if1.gate_op, if1.gate_a, if1.gate_b);
    always_comb if4.gate_y = gate_fn(if4.gate_op, if4.gate_a, if4.gate_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt1(input string name, output logic [3:0] g);
        int n;
        n = 0;
        while (if1.gnt == 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        g = if1.gnt;
        if (g == 4'b0000) begin
            checks++;
            errors++;
            $display("FAIL %s: actual=timeout required=grant within 20 cycles", name);
        end
    endtask

    task automatic set_req1(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        if1.req_op[2*id +: 2] = op;
        if1.req_a[8*id +: 8]  = a;
        if1.req_b[8*id +: 8]  = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs [6];
        logic [7:0] rr_y [4];
        int         rr_ord [5];
        logic [3:0] g;
        logic       saw_valid;

        vecs[0] = '{0, 2'b01, 8'hF0, 8'h3C, 8'h30};
        vecs[1] = '{2, 2'b00, 8'hA5, 8'hFF, 8'h5A};
        vecs[2] = '{1, 2'b10, 8'h0F, 8'h50, 8'h5F};
        vecs[3] = '{3, 2'b11, 8'hFF, 8'h0F, 8'hF0};
        vecs[4] = '{0, 2'b11, 8'hAA, 8'hAA, 8'h00};
        vecs[5] = '{1, 2'b00, 8'h00, 8'h12, 8'hFF};
        rr_y    = '{8'h0F, 8'h1E, 8'h2D, 8'h3C};
        rr_ord  = '{0, 1, 2, 3, 0};

        rst1_n = 1'b0;
        rst4_n = 1'b0;
        if1.req = 4'b0000; if1.req_op = 8'h00; if1.req_a = 32'h0; if1.req_b = 32'h0; if1.rsp_ready = 1'b1;
        if4.req = 4'b0000; if4.req_op = 8'h00; if4.req_a = 32'h0; if4.req_b = 32'h0; if4.rsp_ready = 1'b1;
        tick();
        tick();
        check("rst_gnt",       32'(if1.gnt),       32'h0);
        check("rst_gate_op",   32'(if1.gate_op),   32'h0);
        check("rst_gate_a",    32'(if1.gate_a),    32'h0);
        check("rst_gate_b",    32'(if1.gate_b),    32'h0);
        check("rst_busy",      32'(if1.busy),      32'h0);
        check("rst_rsp_valid", 32'(if1.rsp_valid), 32'h0);
        check("rst_rsp_id",    32'(if1.rsp_id),    32'h0);
        check("rst_rsp_data",  32'(if1.rsp_data),  32'h0);
        rst1_n = 1'b1;
        rst4_n = 1'b1;
        tick();

        // Single-requester transactions, GATE_LAT=1.
        for (int v = 0; v < 6; v++) begin
            set_req1(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b);
            if1.req = 4'b0001 << vecs[v].id;
            wait_gnt1("vec_gnt_wait", g);
            check("vec_gnt",    32'(g),          32'(4'b0001 << vecs[v].id));
            check("vec_gate_a", 32'(if1.gate_a), 32'(vecs[v].a));
            check("vec_busy",   32'(if1.busy),   32'h1);
            if1.req = 4'b0000;
            tick();
            check("vec_valid",  32'(if1.rsp_valid), 32'h1);
            check("vec_data",   32'(if1.rsp_data),  32'(vecs[v].y));
            check("vec_id",     32'(if1.rsp_id),    32'(vecs[v].id));
            check("vec_gnt_pulse", 32'(if1.gnt),    32'h0);
            tick();
            check("vec_valid_clr", 32'(if1.rsp_valid), 32'h0);
            check("vec_idle",      32'(if1.busy),      32'h0);
        end

        // Contention from reset: grant order 0,1,2,3,0.
        rst1_n = 1'b0;
        tick();
        rst1_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req1(i, 2'b11, 8'(8'h11 * i), 8'h0F);
        if1.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_gnt1("rr_gnt_wait", g);
            check("rr_order", 32'(g), 32'(4'b0001 << rr_ord[n]));
            if1.req[rr_ord[n]] = 1'b0;
            tick();
            check("rr_data", 32'(if1.rsp_data), 32'(rr_y[rr_ord[n]]));
            check("rr_id",   32'(if1.rsp_id),   32'(rr_ord[n]));
            tick();
            if1.req[rr_ord[n]] = 1'b1;
        end
        if1.req = 4'b0000;
        tick();

        // Backpressure with requester 1 pending.
        if1.rsp_ready = 1'b0;
        set_req1(0, 2'b01, 8'hFF, 8'hC3);
        set_req1(1, 2'b10, 8'h12, 8'h21);
        if1.req = 4'b0001;
        wait_gnt1("bp_gnt_wait", g);
        check("bp_gnt0", 32'(g), 32'h1);
        if1.req = 4'b0010;
        tick();
        check("bp_valid", 32'(if1.rsp_valid), 32'h1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", 32'(if1.rsp_valid), 32'h1);
            check("bp_hold_data",  32'(if1.rsp_data),  32'hC3);
            check("bp_no_gnt",     32'(if1.gnt),       32'h0);
        end
        if1.rsp_ready = 1'b1;
        tick();
        check("bp_valid_clr", 32'(if1.rsp_valid), 32'h0);
        check("bp_no_gnt_hs", 32'(if1.gnt),       32'h0);
        tick();
        check("bp_gnt1", 32'(if1.gnt), 32'h2);
        if1.req = 4'b0000;
        tick();
        check("bp_data1", 32'(if1.rsp_data), 32'h33);
        check("bp_id1",   32'(if1.rsp_id),   32'h1);
        tick();

        // GATE_LAT=4 latency, then reset in the middle of EXEC.
        if4.req_op[7:6] = 2'b11; if4.req_a[31:24] = 8'h3C; if4.req_b[31:24] = 8'hFF;
        if4.req = 4'b1000;
        tick();
        check("l4_gnt", 32'(if4.gnt), 32'h8);
        if4.req = 4'b0000;
        tick(); tick(); tick();
        check("l4_not_yet", 32'(if4.rsp_valid), 32'h0);
        tick();
        check("l4_valid", 32'(if4.rsp_valid), 32'h1);
        check("l4_data",  32'(if4.rsp_data),  32'hC3);
        check("l4_id",    32'(if4.rsp_id),    32'h3);
        tick();
        if4.req_op[1:0] = 2'b01; if4.req_a[7:0] = 8'hFF; if4.req_b[7:0] = 8'hFF;
        if4.req_op[3:2] = 2'b10; if4.req_a[15:8] = 8'h01; if4.req_b[15:8] = 8'h02;
        if4.req = 4'b0001;
        tick();
        check("ab_gnt", 32'(if4.gnt), 32'h1);
        if4.req = 4'b0000;
        tick(); tick();
        rst4_n = 1'b0;
        #1;
        check("ab_busy",   32'(if4.busy),      32'h0);
        check("ab_gnt0",   32'(if4.gnt),       32'h0);
        check("ab_op",     32'(if4.gate_op),   32'h0);
        check("ab_a",      32'(if4.gate_a),    32'h0);
        check("ab_b",      32'(if4.gate_b),    32'h0);
        check("ab_valid",  32'(if4.rsp_valid), 32'h0);
        check("ab_data",   32'(if4.rsp_data),  32'h0);
        tick();
        rst4_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (if4.rsp_valid) saw_valid = 1'b1;
        end
        check("ab_no_rsp", 32'(saw_valid), 32'h0);
        if4.req = 4'b0011;
        tick();
        check("ab_next_gnt", 32'(if4.gnt), 32'h1);
        if4.req = 4'b0000;

`ifdef GATE_ARB_STATS_EN
        // Statistics: three grants, requester 1 waits six cycles.
        rst1_n = 1'b0;
        tick();
        rst1_n = 1'b1;
        check("st_gc_rst", 32'(gc1), 32'h0);
        check("st_lw_rst", 32'(lw1), 32'h0);
        if1.rsp_ready = 1'b0;
        if1.req = 4'b0001;
        tick();
        check("st_gnt0", 32'(if1.gnt), 32'h1);
        if1.req = 4'b0010;
        tick(); tick(); tick(); tick();
        if1.rsp_ready = 1'b1;
        tick(); tick();
        check("st_gnt1", 32'(if1.gnt), 32'h2);
        check("st_lw",   32'(lw1),     32'h6);
        check("st_gc2",  32'(gc1),     32'h2);
        if1.req = 4'b0000;
        tick(); tick();
        if1.req = 4'b0100;
        tick();
        check("st_gc3", 32'(gc1), 32'h3);
        if1.req = 4'b0000;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
